// File: rtl/axi_console_eoc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : axi_console_eoc                                                  |
// | Brief   : AXI4 slave with line-buffered multi-channel console capture and  |
// |           a sticky end-of-computation / return-value register.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module axi_console_eoc #(
    parameter int NUM_CHANNELS = 4,
    parameter int LINE_DEPTH   = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 6,
    localparam int c_ch_w      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [ID_WIDTH-1:0]     aw_id_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [ID_WIDTH-1:0]     b_id_o,
    output logic [1:0]              b_resp_o,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [ID_WIDTH-1:0]     ar_id_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [ID_WIDTH-1:0]     r_id_o,
    output logic [1:0]              r_resp_o,
    output logic                    cons_valid_o,
    input  logic                    cons_ready_i,
    output logic [c_ch_w-1:0]       cons_ch_o,
    output logic [7:0]              cons_char_o,
    output logic                    cons_last_o,
    output logic                    eoc_o,
    output logic [DATA_WIDTH-1:0]   retval_o
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_idx_w  = $clog2(LINE_DEPTH);
    localparam int c_cnt_w  = c_idx_w + 1;

    localparam logic [1:0]  c_w_idle      = 2'd0;
    localparam logic [1:0]  c_w_data      = 2'd1;
    localparam logic [1:0]  c_w_resp      = 2'd2;
    localparam logic [0:0]  c_r_idle      = 1'b0;
    localparam logic [0:0]  c_r_resp      = 1'b1;
    localparam logic [1:0]  c_kind_con    = 2'd0;
    localparam logic [1:0]  c_kind_eoc    = 2'd1;
    localparam logic [1:0]  c_kind_err    = 2'd2;
    localparam logic [1:0]  c_resp_okay   = 2'b00;
    localparam logic [1:0]  c_resp_slverr = 2'b10;
    localparam logic [15:0] c_off_eoc     = 16'h1000;
    localparam logic [15:0] c_off_status  = 16'h1004;
    localparam logic [7:0]  c_newline     = 8'h0A;

    // Write channel state
    logic [1:0]            r_wstate;
    logic [1:0]            r_w_kind;
    logic [c_ch_w-1:0]     r_w_ch;
    logic [ID_WIDTH-1:0]   r_b_id;
    logic [1:0]            r_b_resp;
    logic                  r_eoc;
    logic [DATA_WIDTH-1:0] r_retval;

    // Read channel state
    logic [0:0]            r_rstate;
    logic [ID_WIDTH-1:0]   r_r_id;
    logic [DATA_WIDTH-1:0] r_r_data;
    logic [1:0]            r_r_resp;

    // Line buffers and flush engine
    logic [7:0]              r_mem     [NUM_CHANNELS][LINE_DEPTH];
    logic [c_cnt_w-1:0]      r_count   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_pending;
    logic                    r_flushing;
    logic [c_ch_w-1:0]       r_grant;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_ch_w-1:0]       r_rr_ptr;

    logic [15:0]             w_aw_off;
    logic [15:0]             w_ar_off;
    logic                    w_aw_is_con;
    logic                    w_ar_is_con;
    logic                    w_w_ready;
    logic                    w_w_hs;
    logic                    w_push;
    logic                    w_fill;
    logic [7:0]              w_byte;
    logic [c_ch_w-1:0]       w_arb_ch;
    logic [c_ch_w-1:0]       w_grant_next;
    logic                    w_cons_last;
    logic [NUM_CHANNELS-1:0] w_status;
    logic                    w_unused;

    assign w_aw_off    = aw_addr_i[15:0];
    assign w_ar_off    = ar_addr_i[15:0];
    assign w_aw_is_con = (w_aw_off[15:2] < 14'(NUM_CHANNELS)) && (w_aw_off[1:0] == 2'b00);
    assign w_ar_is_con = (w_ar_off[15:2] < 14'(NUM_CHANNELS)) && (w_ar_off[1:0] == 2'b00);
    assign w_unused    = ^{aw_addr_i[ADDR_WIDTH-1:16], ar_addr_i[ADDR_WIDTH-1:16]};

    // A full buffer is always pending, so one flag covers both stall causes.
    assign w_w_ready = (r_wstate == c_w_data) &&
                       !((r_w_kind == c_kind_con) && r_pending[r_w_ch]);
    assign w_w_hs    = w_w_ready && w_valid_i;
    assign w_push    = w_w_hs && (r_w_kind == c_kind_con) && (|w_strb_i);
    assign w_fill    = (r_count[r_w_ch] == c_cnt_w'(LINE_DEPTH - 1));

    always_comb begin
        w_byte = '0;
        for (int i = c_strb_w - 1; i >= 0; i--) begin
            if (w_strb_i[i]) w_byte = w_data_i[8*i +: 8];
        end
    end

    // Descending scan so the channel closest after the pointer wins.
    always_comb begin
        w_arb_ch = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (r_pending[(int'(r_rr_ptr) + i) % NUM_CHANNELS])
                w_arb_ch = c_ch_w'((int'(r_rr_ptr) + i) % NUM_CHANNELS);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++)
            w_status[c] = r_pending[c] || (r_count[c] != '0);
    end

    assign w_grant_next = c_ch_w'((int'(r_grant) + 1) % NUM_CHANNELS);
    assign w_cons_last  = ((c_cnt_w'(r_idx) + c_cnt_w'(1)) == r_count[r_grant]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wstate <= c_w_idle;
            r_w_kind <= c_kind_err;
            r_w_ch   <= '0;
            r_b_id   <= '0;
            r_b_resp <= c_resp_okay;
            r_eoc    <= 1'b0;
            r_retval <= '0;
        end else begin
            case (r_wstate)
                c_w_idle: begin
                    if (aw_valid_i) begin
                        r_b_id <= aw_id_i;
                        r_w_ch <= w_aw_off[2 +: c_ch_w];
                        if (w_aw_is_con)                r_w_kind <= c_kind_con;
                        else if (w_aw_off == c_off_eoc) r_w_kind <= c_kind_eoc;
                        else                            r_w_kind <= c_kind_err;
                        r_wstate <= c_w_data;
                    end
                end
                c_w_data: begin
                    if (w_w_hs) begin
                        r_b_resp <= (r_w_kind == c_kind_err) ? c_resp_slverr : c_resp_okay;
                        if ((r_w_kind == c_kind_eoc) && !r_eoc) begin
                            r_eoc    <= 1'b1;
                            r_retval <= w_data_i;
                        end
                        r_wstate <= c_w_resp;
                    end
                end
                c_w_resp: begin
                    if (b_ready_i) r_wstate <= c_w_idle;
                end
                default: r_wstate <= c_w_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rstate <= c_r_idle;
            r_r_id   <= '0;
            r_r_data <= '0;
            r_r_resp <= c_resp_okay;
        end else if (r_rstate == c_r_idle) begin
            if (ar_valid_i) begin
                r_r_id   <= ar_id_i;
                r_rstate <= c_r_resp;
                if (w_ar_off == c_off_status) begin
                    r_r_data <= DATA_WIDTH'(w_status);
                    r_r_resp <= c_resp_okay;
                end else begin
                    r_r_data <= '0;
                    r_r_resp <= (w_ar_is_con || (w_ar_off == c_off_eoc)) ? c_resp_okay
                                                                         : c_resp_slverr;
                end
            end
        end else if (r_ready_i) begin
            r_rstate <= c_r_idle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_w_ch][r_count[r_w_ch][c_idx_w-1:0]] <= w_byte;
    end

    // A push never targets the channel being cleared: it is pending and stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) r_count[c] <= '0;
            r_pending  <= '0;
            r_flushing <= 1'b0;
            r_grant    <= '0;
            r_idx      <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_push) begin
                r_count[r_w_ch] <= r_count[r_w_ch] + c_cnt_w'(1);
                if ((w_byte == c_newline) || w_fill) r_pending[r_w_ch] <= 1'b1;
            end
            if (!r_flushing) begin
                if (|r_pending) begin
                    r_flushing <= 1'b1;
                    r_grant    <= w_arb_ch;
                    r_idx      <= '0;
                end
            end else if (cons_ready_i) begin
                if (w_cons_last) begin
                    r_count[r_grant]   <= '0;
                    r_pending[r_grant] <= 1'b0;
                    r_flushing         <= 1'b0;
                    r_rr_ptr           <= w_grant_next;
                end else begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end
        end
    end

    assign aw_ready_o   = (r_wstate == c_w_idle);
    assign w_ready_o    = w_w_ready;
    assign b_valid_o    = (r_wstate == c_w_resp);
    assign b_id_o       = r_b_id;
    assign b_resp_o     = r_b_resp;
    assign ar_ready_o   = (r_rstate == c_r_idle);
    assign r_valid_o    = (r_rstate == c_r_resp);
    assign r_data_o     = r_r_data;
    assign r_id_o       = r_r_id;
    assign r_resp_o     = r_r_resp;
    assign cons_valid_o = r_flushing;
    assign cons_ch_o    = r_grant;
    assign cons_char_o  = r_mem[r_grant][r_idx];
    assign cons_last_o  = w_cons_last;
    assign eoc_o        = r_eoc;
    assign retval_o     = r_retval;

endmodule
`default_nettype wire

// File: tb/tb_axi_console_eoc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_axi_console_eoc                                               |
// | Brief   : Scoreboard bench for axi_console_eoc with directed vectors.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_axi_console_eoc;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_valid = 1'b0;
    logic [31:0] aw_addr = '0;
    logic [5:0]  aw_id = '0;
    logic        w_valid = 1'b0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        b_ready = 1'b1;
    logic        ar_valid = 1'b0;
    logic [31:0] ar_addr = '0;
    logic [5:0]  ar_id = '0;
    logic        r_ready = 1'b1;
    logic        cons_ready = 1'b1;

    logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o;
    logic [5:0]  b_id_o, r_id_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [31:0] r_data_o, retval_o;
    logic        cons_valid_o, cons_last_o, eoc_o;
    logic [1:0]  cons_ch_o;
    logic [7:0]  cons_char_o;

    axi_console_eoc dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .aw_valid_i   (aw_valid),
        .aw_ready_o   (aw_ready_o),
        .aw_addr_i    (aw_addr),
        .aw_id_i      (aw_id),
        .w_valid_i    (w_valid),
        .w_ready_o    (w_ready_o),
        .w_data_i     (w_data),
        .w_strb_i     (w_strb),
        .b_valid_o    (b_valid_o),
        .b_ready_i    (b_ready),
        .b_id_o       (b_id_o),
        .b_resp_o     (b_resp_o),
        .ar_valid_i   (ar_valid),
        .ar_ready_o   (ar_ready_o),
        .ar_addr_i    (ar_addr),
        .ar_id_i      (ar_id),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready),
        .r_data_o     (r_data_o),
        .r_id_o       (r_id_o),
        .r_resp_o     (r_resp_o),
        .cons_valid_o (cons_valid_o),
        .cons_ready_i (cons_ready),
        .cons_ch_o    (cons_ch_o),
        .cons_char_o  (cons_char_o),
        .cons_last_o  (cons_last_o),
        .eoc_o        (eoc_o),
        .retval_o     (retval_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cons_hs = 0;

    logic [7:0]  exp_b [$];   // {id, resp}
    logic [39:0] exp_r [$];   // {id, resp, data}
    logic [10:0] exp_c [$];   // {ch, char, last}
    logic [7:0]  eb;
    logic [39:0] er;
    logic [10:0] ec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes complete at the next posedge, observed at negedge.
    always @(negedge clk) begin
        if (b_valid_o && b_ready) begin
            if (exp_b.size() == 0) check("b_unexpected", 64'd1, 64'd0);
            else begin
                eb = exp_b.pop_front();
                check("b_id_resp", 64'({b_id_o, b_resp_o}), 64'(eb));
            end
        end
        if (r_valid_o && r_ready) begin
            if (exp_r.size() == 0) check("r_unexpected", 64'd1, 64'd0);
            else begin
                er = exp_r.pop_front();
                check("r_id_resp_data", 64'({r_id_o, r_resp_o, r_data_o}), 64'(er));
            end
        end
        if (cons_valid_o && cons_ready) begin
            cons_hs++;
            if (exp_c.size() == 0) check("cons_unexpected", 64'd1, 64'd0);
            else begin
                ec = exp_c.pop_front();
                check("cons_ch_char_last", 64'({cons_ch_o, cons_char_o, cons_last_o}), 64'(ec));
            end
        end
    end

    task automatic wait_hs(input string name, input int which, input int budget);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((which == 0 && aw_ready_o) || (which == 1 && w_ready_o) ||
                (which == 2 && ar_ready_o)) break;
            n++;
            if (n > budget) begin
                check({name, "_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [5:0] id);
        aw_valid = 1'b1; aw_addr = addr; aw_id = id;
        wait_hs("aw", 0, 400);
        @(posedge clk); #1 aw_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [5:0] id, input logic [1:0] resp);
        exp_b.push_back({id, resp});
        aw_phase(addr, id);
        w_valid = 1'b1; w_data = data; w_strb = strb;
        wait_hs("w", 1, 400);
        @(posedge clk); #1 w_valid = 1'b0;
    endtask

    task automatic con_write(input int ch, input logic [7:0] c);
        do_write(32'(4 * ch), {24'd0, c}, 4'b0001, 6'(ch + 1), OKAY);
    endtask

    task automatic push_c(input logic [1:0] ch, input logic [7:0] c, input logic last);
        exp_c.push_back({ch, c, last});
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [5:0] id,
                           input logic [31:0] data, input logic [1:0] resp);
        exp_r.push_back({id, resp, data});
        ar_valid = 1'b1; ar_addr = addr; ar_id = id;
        wait_hs("ar", 2, 400);
        @(posedge clk); #1 ar_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0 || exp_c.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_leftover"}, 64'(exp_b.size() + exp_r.size() + exp_c.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_aw_ready", 64'(aw_ready_o), 64'd1);
        check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
        check("rst_w_ready", 64'(w_ready_o), 64'd0);
        check("rst_b_valid", 64'(b_valid_o), 64'd0);
        check("rst_r_valid", 64'(r_valid_o), 64'd0);
        check("rst_cons_valid", 64'(cons_valid_o), 64'd0);
        check("rst_eoc", 64'(eoc_o), 64'd0);
        check("rst_retval", 64'(retval_o), 64'd0);

        // Routing and byte-lane selection on channel 1
        do_write(32'h4, 32'h0000_0041, 4'b0000, 6'h11, OKAY);
        do_write(32'h4, 32'h0000_0048, 4'b0001, 6'h12, OKAY);
        do_write(32'h4, 32'h0000_6900, 4'b0010, 6'h13, OKAY);
        do_write(32'h4, 32'h0B0A_0000, 4'b1100, 6'h14, OKAY);
        push_c(2'd1, 8'h48, 1'b0);
        push_c(2'd1, 8'h69, 1'b0);
        push_c(2'd1, 8'h0A, 1'b1);
        drain("routing");

        // Arbitration with the stream held back
        cons_ready = 1'b0;
        con_write(0, 8'h41); con_write(0, 8'h0A);
        con_write(2, 8'h42); con_write(2, 8'h0A);
        push_c(2'd0, 8'h41, 1'b0); push_c(2'd0, 8'h0A, 1'b1);
        push_c(2'd2, 8'h42, 1'b0); push_c(2'd2, 8'h0A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_cons", 64'({cons_valid_o, cons_ch_o, cons_char_o}), {53'd0, 1'b1, 2'd0, 8'h41});
        end
        @(posedge clk); #1 cons_ready = 1'b1;
        drain("arb");
        con_write(0, 8'h43); con_write(0, 8'h0A);
        push_c(2'd0, 8'h43, 1'b0); push_c(2'd0, 8'h0A, 1'b1);
        drain("arb_again");

        // Status and read responses
        con_write(3, 8'h78);
        do_read(32'h1004, 6'h21, 32'h8, OKAY);
        do_read(32'h1000, 6'h22, 32'h0, OKAY);
        do_read(32'h0004, 6'h23, 32'h0, OKAY);
        do_read(32'h3000, 6'h24, 32'h0, SLVERR);
        do_write(32'h2000, 32'hDEAD_BEEF, 4'b1111, 6'h25, SLVERR);
        drain("status");
        check("err_no_eoc", 64'(eoc_o), 64'd0);
        do_read(32'h1004, 6'h26, 32'h8, OKAY);

        // EOC register
        do_write(32'h1000, 32'h2A, 4'b1111, 6'h30, OKAY);
        check("eoc_set", 64'(eoc_o), 64'd1);
        check("retval_42", 64'(retval_o), 64'd42);
        do_write(32'h1000, 32'h7, 4'b1111, 6'h31, OKAY);
        check("retval_sticky", 64'(retval_o), 64'd42);
        drain("eoc");

        // B backpressure while terminating channel 3's line
        b_ready = 1'b0;
        do_write(32'hC, 32'h0A, 4'b0001, 6'h15, OKAY);
        push_c(2'd3, 8'h78, 1'b0); push_c(2'd3, 8'h0A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_hold", 64'({b_valid_o, b_id_o, b_resp_o, aw_ready_o}), {55'd0, 1'b1, 6'h15, OKAY, 1'b0});
        end
        @(posedge clk); #1 b_ready = 1'b1;
        drain("bp");

        // Overflow: 64 bytes fill channel 0, the 65th write stalls until flushed
        for (int i = 0; i < 64; i++) begin
            con_write(0, 8'h61);
            push_c(2'd0, 8'h61, (i == 63));
        end
        base = cons_hs;
        exp_b.push_back({6'h3F, OKAY});
        aw_phase(32'h0, 6'h3F);
        w_valid = 1'b1; w_data = 32'h61; w_strb = 4'b0001;
        wait_hs("w65", 1, 400);
        check("stall_until_flushed", 64'(cons_hs - base), 64'd64);
        @(posedge clk); #1 w_valid = 1'b0;
        drain("overflow");

        // Reset in the middle of a flush
        cons_ready = 1'b0;
        do_write(32'h0, 32'h0A, 4'b0001, 6'h07, OKAY);
        drain("pre_reset");
        repeat (2) @(negedge clk);
        check("flush_started", 64'(cons_valid_o), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid_cons_valid", 64'(cons_valid_o), 64'd0);
        check("rst_mid_eoc", 64'(eoc_o), 64'd0);
        cons_ready = 1'b1;
        do_read(32'h1004, 6'h2A, 32'h0, OKAY);
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_console_eoc.md
# axi_console_eoc

Synthesisable AXI4 slave for the cluster's console and end-of-computation region. It replaces the behavioural UART and EOC bus models with line-buffered, multi-channel print capture and a sticky end-of-computation register. Print lines leave as a byte stream, one complete line at a time. The block sits on one master port of the system AXI crossbar, in the console/EOC address window.

## Interface
Parameters:
- NumChannels, 4, independent print channels (power of two, 1..16)
- LineDepth, 64, byte buffer depth per channel (power of two, ≥2)
- AddrWidth, 32, AXI address width
- DataWidth, 32, AXI data width (32 or 64)
- IdWidth, 6, AXI ID width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- aw_valid_i / aw_ready_o  in/out  1  AW handshake
- aw_addr_i  in  AddrWidth  write address
- aw_id_i  in  IdWidth  write ID
- w_valid_i / w_ready_o  in/out  1  W handshake
- w_data_i  in  DataWidth  write data
- w_strb_i  in  DataWidth/8  write strobes
- b_valid_o / b_ready_i  out/in  1  B handshake
- b_id_o  out  IdWidth  response ID
- b_resp_o  out  2  OKAY (00) or SLVERR (10)
- ar_valid_i / ar_ready_o  in/out  1  AR handshake
- ar_addr_i  in  AddrWidth  read address
- ar_id_i  in  IdWidth  read ID
- r_valid_o / r_ready_i  out/in  1  R handshake
- r_data_o  out  DataWidth  read data
- r_id_o  out  IdWidth  read ID
- r_resp_o  out  2  read response
- cons_valid_o / cons_ready_i  out/in  1  console stream handshake
- cons_ch_o  out  $clog2(NumChannels) (min 1)  channel of the current byte
- cons_char_o  out  8  byte
- cons_last_o  out  1  last byte of the line
- eoc_o  out  1  end of computation, sticky
- retval_o  out  DataWidth  return value

## Operation
- Only offset bits [15:0] are decoded. Bursts are unsupported; every transfer is treated as a single beat.
- Address map:
  - 0x0000 + 4·c: console channel c, for c < NumChannels.
  - 0x1000: EOC register.
  - 0x1004: status register, read-only. Bit c is 1 when channel c holds a non-empty buffer or a pending flush.
  - Any other offset: SLVERR with no side effect. Reads return data 0.
- Write FSM states:
  - W_IDLE: aw_ready=1. On handshake, latch address and ID, go to W_DATA.
  - W_DATA: w_ready=1 unless the target channel is pending or flushing. On handshake, perform the side effect and go to W_RESP.
  - W_RESP: b_valid=1. On b_ready, go to W_IDLE.
  - Only one write is outstanding at a time.
- Console write:
  - The byte comes from the lowest byte lane with its strobe set. If the strobe is all zeros, nothing is pushed and the response is still OKAY.
  - The byte is pushed into channel c's buffer.
  - If the byte is 0x0A, or the push fills the buffer to LineDepth, channel c becomes pending.
- EOC write:
  - The first EOC write sets eoc_o=1 and retval_o=w_data.
  - Later EOC writes return OKAY and are ignored.
- Read FSM, independent of the write FSM:
  - R_IDLE: ar_ready=1.
  - R_RESP: r_valid=1 with data held until r_ready.
  - Status reads return OKAY. Reads of console or EOC offsets return data 0 with OKAY.
- Flush engine:
  - Round-robin arbiter over the pending channels. The pointer starts after the last channel served.
  - Streams bytes 0..count-1 of the granted channel. cons_last=1 on byte count-1.
  - After the last handshake, count clears and pending clears.
  - A line is never interleaved with another channel's line.

## Timing
- After a reset edge:
  - aw_ready=1, ar_ready=1.
  - w_ready=0, b_valid=0, r_valid=0, cons_valid=0.
  - eoc_o=0, retval_o=0.
  - All buffers empty, nothing pending, arbiter pointer at 0.
- Reset mid-flush or mid-transaction discards all state. No partial line is emitted.
- AW handshake at cycle t gives w_ready=1 at t+1 at the earliest.
- W handshake at cycle u gives b_valid=1 at u+1. eoc_o and retval_o update at u+1.
- A pending flag set at cycle u+1 gives cons_valid=1 at u+2 at the earliest.
- Console stream throughput is 1 byte/cycle while cons_ready=1.
- cons_* and b_*/r_* outputs stay stable while valid is high and ready is low.
- If the buffer for channel c is full or pending, a write to c stalls in W_DATA until its flush completes. Other channels are unaffected.
- If a push and a flush completion hit the same channel in the same cycle, the push cannot happen, because the stall rule prevents it.

## Test plan
- Channel routing: write 'H', 'i', 0x0A to 0x0004 → three B OKAY responses; stream emits ch=1 bytes 0x48, 0x69, 0x0A, with last only on 0x0A.
- Overflow (LineDepth=64): 64 writes of 'a' to channel 0 → 64-byte line, last on byte 64. The 65th write's w_ready stays low until that last handshake.
- Arbitration: "A\n" to channel 0 and "B\n" to channel 2, with cons_ready held 0 and then released → ch0 line fully, then ch2 line, no mixing. A new ch0 line after that is served after ch2.
- EOC behaviour:
  - Write 0x2A to 0x1000 → eoc_o=1 and retval_o=42 one cycle after the W handshake.
  - A later write of 7 → B OKAY and retval_o stays 42.
- Error and status:
  - Write to 0x2000 → SLVERR, no state change.
  - With "x" left unterminated in channel 3, read 0x1004 → r_data=0x8, OKAY.
- Backpressure:
  - b_ready=0 for 5 cycles → b_valid, b_id and b_resp held, aw_ready=0 throughout.
  - Reset asserted during a flush → cons_valid=0 next cycle and status reads 0.
